// File: rtl/frv_asi_issue_pkg.sv
// Shared types and constants for the ASI issue/holding stage.
package frv_asi_issue_pkg;

    // Issue stage states, 2-bit encoding shared with the rest of the ASI path.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } issue_state_t;

    localparam int ASI_UOP_W = 5;

    // ASI micro-op codes used by the execute path.
    localparam logic [ASI_UOP_W-1:0] ASI_SHA256_S0 = 5'd4;
    localparam logic [ASI_UOP_W-1:0] ASI_SHA256_S1 = 5'd5;
    localparam logic [ASI_UOP_W-1:0] ASI_SHA256_S2 = 5'd6;
    localparam logic [ASI_UOP_W-1:0] ASI_SHA256_S3 = 5'd7;

endpackage

// File: rtl/frv_asi_issue_if.sv
// Bundle of dispatch, ASI-unit and writeback signals around the issue stage.
interface frv_asi_issue_if #(
    parameter int XLEN  = 32,
    parameter int UOP_W = 5,
    parameter int CNT_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [UOP_W-1:0] s_uop;
    logic [XLEN-1:0]  s_rs1;
    logic [XLEN-1:0]  s_rs2;
    logic [1:0]       s_shamt;
    logic [4:0]       s_rd;
    logic             flush;
    logic             asi_valid;
    logic             asi_ready;
    logic             asi_flush;
    logic [UOP_W-1:0] asi_uop;
    logic [XLEN-1:0]  asi_rs1;
    logic [XLEN-1:0]  asi_rs2;
    logic [1:0]       asi_shamt;
    logic [XLEN-1:0]  asi_result;
    logic             wb_valid;
    logic             wb_ready;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_result;
    logic [CNT_W-1:0] stall_count;

    // Issue stage side.
    modport slave (
        input  s_valid, s_uop, s_rs1, s_rs2, s_shamt, s_rd, flush,
        input  asi_ready, asi_result, wb_ready,
        output s_ready, asi_valid, asi_flush, asi_uop, asi_rs1, asi_rs2,
        output asi_shamt, wb_valid, wb_rd, wb_result, stall_count
    );

    // Surrounding pipeline side (dispatch, ASI unit, writeback).
    modport master (
        output s_valid, s_uop, s_rs1, s_rs2, s_shamt, s_rd, flush,
        output asi_ready, asi_result, wb_ready,
        input  s_ready, asi_valid, asi_flush, asi_uop, asi_rs1, asi_rs2,
        input  asi_shamt, wb_valid, wb_rd, wb_result, stall_count
    );
endinterface

// File: rtl/frv_sat_counter.sv
// Saturating up-counter with synchronous active-low clear, for perf counters.
module frv_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on enable, sticking at all-ones; clear has priority.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/frv_asi_issue.sv
// Issue/holding stage in front of the ASI unit: accepts one op, holds its
// operands until the unit answers, registers the result for writeback.
module frv_asi_issue #(
    parameter int XLEN  = 32,
    parameter int UOP_W = 5,
    parameter int CNT_W = 16
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    frv_asi_issue_if.slave bus
);
    import frv_asi_issue_pkg::*;

    issue_state_t     state_q;
    issue_state_t     state_d;
    logic             s_ready_w;
    logic             accept;
    logic             capture_op;
    logic             capture_wb;
    logic             stall_inc;
    logic             in_busy;
    logic [UOP_W-1:0] uop_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [1:0]       shamt_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  wb_result_q;
    logic [4:0]       wb_rd_q;

    // Decide when dispatch may hand over an op; flush and reset block intake.
    always_comb begin
        s_ready_w = 1'b0;
        if (g_resetn && !bus.flush) begin
            case (state_q)
                ST_IDLE: s_ready_w = 1'b1;
                ST_DONE: s_ready_w = bus.wb_ready;
                default: s_ready_w = 1'b0;
            endcase
        end
    end

    assign accept = bus.s_valid && s_ready_w;

    // Next-state and capture strobes; a flush overrides everything else.
    always_comb begin
        state_d    = state_q;
        capture_op = 1'b0;
        capture_wb = 1'b0;
        stall_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_BUSY;
                    capture_op = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus.asi_ready) begin
                    state_d    = ST_DONE;
                    capture_wb = 1'b1;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.wb_ready) begin
                    if (accept) begin
                        state_d    = ST_BUSY;
                        capture_op = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_d    = ST_IDLE;
            capture_op = 1'b0;
            capture_wb = 1'b0;
            stall_inc  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand holding registers, loaded on every accepted op.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            uop_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            shamt_q <= '0;
            rd_q    <= '0;
        end else if (capture_op) begin
            uop_q   <= bus.s_uop;
            rs1_q   <= bus.s_rs1;
            rs2_q   <= bus.s_rs2;
            shamt_q <= bus.s_shamt;
            rd_q    <= bus.s_rd;
        end
    end

    // Writeback registers, loaded when the ASI unit answers; held otherwise.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wb_result_q <= '0;
            wb_rd_q     <= '0;
        end else if (capture_wb) begin
            wb_result_q <= bus.asi_result;
            wb_rd_q     <= rd_q;
        end
    end

    frv_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (g_clk),
        .clr_n (g_resetn),
        .inc   (stall_inc),
        .count (bus.stall_count)
    );

    assign in_busy = (state_q == ST_BUSY);

    // Operand outputs are zeroed outside BUSY to keep the ASI datapath quiet.
    assign bus.s_ready   = s_ready_w;
    assign bus.asi_flush = bus.flush;
    assign bus.asi_valid = g_resetn && in_busy;
    assign bus.asi_uop   = in_busy ? uop_q   : '0;
    assign bus.asi_rs1   = in_busy ? rs1_q   : '0;
    assign bus.asi_rs2   = in_busy ? rs2_q   : '0;
    assign bus.asi_shamt = in_busy ? shamt_q : '0;
    assign bus.wb_valid  = g_resetn && (state_q == ST_DONE);
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_result = wb_result_q;

endmodule

// File: tb/tb_frv_asi_issue.sv
// Self-checking bench for frv_asi_issue: directed scenarios then random
// traffic, compared cycle by cycle against a transaction-level model.
module tb_frv_asi_issue;
    import frv_asi_issue_pkg::*;

    typedef struct {
        logic [4:0]  uop;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  sh;
        logic [4:0]  rd;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: an op waiting for the ASI unit, a result waiting for writeback.
    bit          m_op_pending;
    bit          m_res_pending;
    op_t         m_op;
    logic [31:0] m_wb_res;
    logic [4:0]  m_wb_rd;
    int          m_stalls;

    frv_asi_issue_if #(.XLEN(32), .UOP_W(5), .CNT_W(16)) bus  ();
    frv_asi_issue_if #(.XLEN(32), .UOP_W(5), .CNT_W(4))  bus4 ();

    frv_asi_issue #(.XLEN(32), .UOP_W(5), .CNT_W(16)) dut (
        .g_clk    (clk),
        .g_resetn (rst_n),
        .bus      (bus)
    );

    frv_asi_issue #(.XLEN(32), .UOP_W(5), .CNT_W(4)) dut4 (
        .g_clk    (clk),
        .g_resetn (rst_n),
        .bus      (bus4)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        ror32 = (n == 0) ? x : ((x >> n) | (x << (32 - n)));
    endfunction

    // Behavioural ASI unit: SHA-256 sigma functions plus a generic mix.
    function automatic logic [31:0] asi_fn(input logic [4:0] uop, input logic [31:0] a,
                                           input logic [31:0] b, input logic [1:0] sh);
        case (uop)
            ASI_SHA256_S0: asi_fn = ror32(a, 7) ^ ror32(a, 18) ^ (a >> 3);
            ASI_SHA256_S1: asi_fn = ror32(a, 17) ^ ror32(a, 19) ^ (a >> 10);
            default:       asi_fn = a ^ ror32(b, 8 * int'(sh)) ^ {27'd0, uop};
        endcase
    endfunction

    assign bus.asi_result  = asi_fn(bus.asi_uop, bus.asi_rs1, bus.asi_rs2, bus.asi_shamt);
    assign bus4.asi_result = asi_fn(bus4.asi_uop, bus4.asi_rs1, bus4.asi_rs2, bus4.asi_shamt);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic vld, input logic [4:0] uop,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [1:0] sh, input logic [4:0] rd,
                                 input logic fl, input logic ardy, input logic wrdy);
        rst_n = rst;
        bus.s_valid   = vld;  bus4.s_valid   = vld;
        bus.s_uop     = uop;  bus4.s_uop     = uop;
        bus.s_rs1     = rs1;  bus4.s_rs1     = rs1;
        bus.s_rs2     = rs2;  bus4.s_rs2     = rs2;
        bus.s_shamt   = sh;   bus4.s_shamt   = sh;
        bus.s_rd      = rd;   bus4.s_rd      = rd;
        bus.flush     = fl;   bus4.flush     = fl;
        bus.asi_ready = ardy; bus4.asi_ready = ardy;
        bus.wb_ready  = wrdy; bus4.wb_ready  = wrdy;
    endtask

    // Compare every output against what the model predicts for this cycle.
    task automatic checkOutput();
        bit rdy;
        int sat16;
        int sat4;
        rdy   = rst_n && !bus.flush &&
                ((!m_op_pending && !m_res_pending) || (m_res_pending && bus.wb_ready));
        sat16 = (m_stalls > 65535) ? 65535 : m_stalls;
        sat4  = (m_stalls > 15) ? 15 : m_stalls;
        chk("s_ready",   64'(bus.s_ready),   64'(rdy));
        chk("asi_flush", 64'(bus.asi_flush), 64'(bus.flush));
        chk("asi_valid", 64'(bus.asi_valid), 64'(rst_n && m_op_pending));
        chk("asi_uop",   64'(bus.asi_uop),   m_op_pending ? 64'(m_op.uop) : 64'd0);
        chk("asi_rs1",   64'(bus.asi_rs1),   m_op_pending ? 64'(m_op.rs1) : 64'd0);
        chk("asi_rs2",   64'(bus.asi_rs2),   m_op_pending ? 64'(m_op.rs2) : 64'd0);
        chk("asi_shamt", 64'(bus.asi_shamt), m_op_pending ? 64'(m_op.sh)  : 64'd0);
        chk("wb_valid",  64'(bus.wb_valid),  64'(rst_n && m_res_pending));
        chk("wb_rd",     64'(bus.wb_rd),     64'(m_wb_rd));
        chk("wb_result", 64'(bus.wb_result), 64'(m_wb_res));
        chk("stall16",   64'(bus.stall_count),  64'(sat16));
        chk("stall4",    64'(bus4.stall_count), 64'(sat4));
        chk("wb_valid4", 64'(bus4.wb_valid), 64'(rst_n && m_res_pending));
    endtask

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic modelUpdate();
        if (!rst_n) begin
            m_op_pending  = 0;
            m_res_pending = 0;
            m_wb_res      = '0;
            m_wb_rd       = '0;
            m_stalls      = 0;
            m_op          = '{uop: '0, rs1: '0, rs2: '0, sh: '0, rd: '0};
        end else if (bus.flush) begin
            m_op_pending  = 0;
            m_res_pending = 0;
        end else if (m_op_pending) begin
            if (bus.asi_ready) begin
                m_wb_res      = asi_fn(m_op.uop, m_op.rs1, m_op.rs2, m_op.sh);
                m_wb_rd       = m_op.rd;
                m_op_pending  = 0;
                m_res_pending = 1;
            end else begin
                m_stalls++;
            end
        end else if (!m_res_pending || bus.wb_ready) begin
            m_res_pending = 0;
            if (bus.s_valid) begin
                m_op = '{uop: bus.s_uop, rs1: bus.s_rs1, rs2: bus.s_rs2,
                         sh: bus.s_shamt, rd: bus.s_rd};
                m_op_pending = 1;
            end
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput();
            @(posedge clk);
            modelUpdate();
            #1;
        end
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        $display("[TB] start");
        m_op_pending  = 0;
        m_res_pending = 0;
        m_stalls      = 0;

        // Reset.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        modelUpdate();
        #1;
        runCycles(2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        runCycles(1);

        // Single-cycle SHA256_S0.
        r2 = $urandom;
        applyStimulus(1, 1, ASI_SHA256_S0, 32'h61626364, r2, 2'd1, 5'd7, 0, 1, 1);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        runCycles(3);

        // Multi-cycle op: four stalled BUSY cycles then ready.
        r1 = $urandom; r2 = $urandom;
        applyStimulus(1, 1, ASI_SHA256_S1, r1, r2, 2'd2, 5'd12, 0, 0, 1);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        runCycles(4);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        runCycles(2);

        // Writeback backpressure, then wb_ready with a new op back-to-back.
        r1 = $urandom; r2 = $urandom;
        applyStimulus(1, 1, 5'd9, r1, r2, 2'd3, 5'd21, 0, 1, 0);
        runCycles(2);
        applyStimulus(1, 1, 5'd9, r1, r2, 2'd3, 5'd21, 0, 0, 0);
        runCycles(3);
        r1 = $urandom; r2 = $urandom;
        applyStimulus(1, 1, ASI_SHA256_S2, r1, r2, 2'd0, 5'd3, 0, 0, 1);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        runCycles(3);

        // Flush in BUSY coinciding with asi_ready, then immediate new accept.
        r1 = $urandom; r2 = $urandom;
        applyStimulus(1, 1, ASI_SHA256_S3, r1, r2, 2'd1, 5'd30, 0, 0, 1);
        runCycles(1);
        applyStimulus(1, 1, 5'd1, r1, r2, 2'd1, 5'd30, 1, 1, 1);
        runCycles(1);
        applyStimulus(1, 1, 5'd2, r2, r1, 2'd2, 5'd17, 0, 1, 1);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        runCycles(3);

        // Reset in the middle of an op.
        r1 = $urandom; r2 = $urandom;
        applyStimulus(1, 1, 5'd11, r1, r2, 2'd2, 5'd9, 0, 0, 1);
        runCycles(2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        runCycles(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        runCycles(1);

        // Long stall to saturate the narrow counter.
        r1 = $urandom; r2 = $urandom;
        applyStimulus(1, 1, 5'd13, r1, r2, 2'd0, 5'd1, 0, 0, 1);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        runCycles(20);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        runCycles(2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) != 0),
                          1'($urandom_range(0, 1)),
                          5'($urandom), $urandom, $urandom,
                          2'($urandom), 5'($urandom),
                          ($urandom_range(0, 14) == 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) != 0));
            runCycles(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frv_asi_issue.md
# frv_asi_issue

Issue/holding stage directly upstream of the algorithm-specific-instruction (ASI) unit in the FRV core's execute path. Accepts one ASI micro-op per valid/ready handshake from dispatch and registers its operands. Holds them stable on the ASI unit's inputs until the unit reports `asi_ready`, then registers the result for writeback. Also owns ASI flush sequencing and a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `UOP_W`, 5: micro-op width; matches the ASI uop field in `frv_common.vh`.
- `CNT_W`, 16: stall-counter width.

Ports:
- `g_clk`  in  1: global clock; single clock domain.
- `g_resetn`  in  1: synchronous, active-low reset.
- `s_valid`  in  1: dispatch presents an ASI op.
- `s_ready`  out  1: block can accept an op this cycle.
- `s_uop`  in  UOP_W: micro-op.
- `s_rs1`, `s_rs2`  in  XLEN: source operands.
- `s_shamt`  in  2: shift / byte-select immediate.
- `s_rd`  in  5: destination register index.
- `flush`  in  1: pipeline flush; kills any in-flight op.
- `asi_valid`  out  1: drives ASI unit `asi_valid`.
- `asi_ready`  in  1: ASI unit result valid this cycle.
- `asi_flush`  out  1: drives ASI unit `asi_flush`.
- `asi_uop`  out  UOP_W: held uop.
- `asi_rs1`, `asi_rs2`  out  XLEN: held operands.
- `asi_shamt`  out  2: held immediate.
- `asi_result`  in  XLEN: ASI unit result.
- `wb_valid`  out  1: writeback data valid.
- `wb_ready`  in  1: writeback accepts.
- `wb_rd`  out  5: destination index.
- `wb_result`  out  XLEN: registered result.
- `stall_count`  out  CNT_W: saturating count of BUSY cycles with `asi_ready` low.

## Operation
State machine:
- **IDLE**
  - `s_ready=1`.
  - `s_valid` with no flush: capture `uop`, `rs1`, `rs2`, `shamt`, `rd`; go to BUSY.
- **BUSY**
  - `asi_valid=1`; `asi_uop`/`asi_rs*`/`asi_shamt` come from the held registers.
  - `asi_ready=1`: capture `asi_result` into `wb_result`, `rd` into `wb_rd`; go to DONE.
  - Otherwise stay in BUSY and increment `stall_count`.
- **DONE**
  - `wb_valid=1`.
  - `wb_ready=1`: go to IDLE.
  - If `s_valid` is also high in the same cycle, capture the new op and go straight to BUSY.
  - `s_ready = wb_ready` in this state.

Output gating:
- `asi_uop`, `asi_rs1`, `asi_rs2`, `asi_shamt` are forced to zero outside BUSY.
- This prevents toggling in the ASI datapath while idle.

Flush:
- `asi_flush = flush`, combinationally, in every state.
- Any state with `flush=1` goes to IDLE next cycle.
- `s_ready=0` while `flush=1`; flush beats accept.
- A result arriving with `asi_ready=1` in the flush cycle is discarded.
- A DONE result not yet taken is dropped; `wb_valid` is 0 the next cycle.
- `stall_count` is not modified by flush.

Counter:
- `stall_count` saturates at all-ones.
- It is cleared only by reset.

Protocol rules:
- `wb_rd` and `wb_result` stay stable while `wb_valid=1` and `wb_ready=0`.
- Upstream may drop `s_valid` freely; no transfer happens unless `s_ready` is high.

## Timing
- Reset (`g_resetn=0` at a clock edge):
  - State goes to IDLE.
  - All held registers, `wb_result`, `wb_rd` and `stall_count` go to 0.
  - While `g_resetn=0`: `s_ready=0`, `asi_valid=0`, `wb_valid=0`.
  - `asi_flush` follows `flush`.
- Reset mid-operation abandons the op with no writeback.
- Latency, accept at edge N:
  - BUSY during cycle N+1.
  - If the ASI unit is single-cycle (`asi_ready=1` in N+1), `wb_valid=1` in cycle N+2.
  - A k-cycle ASI op gives `wb_valid` in cycle N+1+k.
- Throughput: one op per 2 cycles with a single-cycle ASI unit and `wb_ready` held high (DONE→BUSY back-to-back).
- `asi_ready` is sampled only in BUSY; it is ignored in IDLE and DONE.

## Structure
- The state encoding (IDLE/BUSY/DONE, 2-bit) and `UOP_W` belong in `frv_common.vh` alongside the existing ASI uop constants.
- One natural sub-module: `frv_sat_counter` (parameterised width, increment enable, synchronous active-low clear). It is reusable by other perf counters.
- The remaining logic stays flat.
- `asi_flush_aessub`, `asi_flush_aesmix` and `asi_flush_data` on the ASI unit are out of scope and tied off by the parent.

## Test plan
- **Single-cycle op.** Reset, accept `uop=SHA256_S0`, `rs1=0x61626364`, `asi_ready` tied 1, `wb_ready=1`.
  - `asi_valid` high exactly 1 cycle.
  - `wb_valid` at N+2 with `wb_result` equal to the model value and the correct `wb_rd`.
- **Multi-cycle op.** `asi_ready` low for 4 BUSY cycles, then high.
  - `asi_rs1`/`asi_rs2` stable all 5 cycles.
  - `stall_count` advances 0→4.
  - `wb_valid` at N+6.
- **Writeback backpressure.** `wb_ready=0` for 3 cycles in DONE.
  - `wb_result`/`wb_rd` stable, `s_ready=0`.
  - Raising `wb_ready` together with `s_valid` takes the next op with no idle cycle.
- **Flush in BUSY.** `flush=1` in the same cycle as `asi_ready=1`.
  - `asi_flush=1` that cycle, IDLE next cycle.
  - `wb_valid` never asserts; a new accept succeeds the following cycle.
- **Reset mid-op.** `g_resetn=0` during BUSY.
  - Next cycle: all outputs 0, `stall_count=0`.
  - After release: `s_ready=1`.
- **Saturation.** With `CNT_W=4`, 20 stalled BUSY cycles leave `stall_count=0xF`.
